// File: rtl/noc_flit_injector.sv
// Clocked source-side bridge: buffers payload words in a FIFO and injects {dest, src, payload}
// flits into an asynchronous NoC router over a 4-phase req/ack handshake. Optional counter: NOC_INJ_PKT_CNT_EN.
module noc_flit_injector #(
  parameter int ADDR_W      = 2,
  parameter int PAYLOAD_W   = 7,
  parameter int SRC_ID      = 0,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_dest,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  output logic                          out_req,
  input  logic                          out_ack,
  output logic [2*ADDR_W+PAYLOAD_W-1:0] out_flit,
  output logic                          drop_pulse,
  output logic [15:0]                   pkt_cnt
);

  localparam int ENTRY_W = ADDR_W + PAYLOAD_W;
  localparam int FLIT_W  = 2*ADDR_W + PAYLOAD_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SRC_ADDR = SRC_ID[ADDR_W-1:0];

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t                 r_state;
  logic                   r_req;
  logic [FLIT_W-1:0]      r_flit;
  logic                   r_drop;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [ENTRY_W-1:0]     r_mem [DEPTH];
  logic [PTR_W:0]         r_wr_ptr;
  logic [PTR_W:0]         r_rd_ptr;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_self;
  logic               w_push;
  logic               w_pop;
  logic               w_ack_s;
  logic               w_done;
  logic [ENTRY_W-1:0] w_head;

  // Full when the pointers match in index but differ in the wrap bit.
  assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign in_ready = !w_full;
  assign w_accept = in_valid && !w_full;
  assign w_self   = (in_dest == SRC_ADDR);
  assign w_push   = w_accept && !w_self;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_head   = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
  assign w_done   = (r_state == REQ_LO) && !w_ack_s;

  assign out_req    = r_req;
  assign out_flit   = r_flit;
  assign drop_pulse = r_drop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_dest, in_payload};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= 1'b0;
      r_ack_sync <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_drop     <= w_accept && w_self;
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
    end
  end

  // The flit register is only reloaded in IDLE, so data stays bundled with req for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_flit  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_flit  <= {w_head[ENTRY_W-1 -: ADDR_W], SRC_ADDR, w_head[PAYLOAD_W-1:0]};
            r_req   <= 1'b1;
            r_state <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!w_ack_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_INJ_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_done) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`else
  logic w_done_unused;

  assign w_done_unused = w_done;
  assign pkt_cnt       = '0;
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed self-checking bench for noc_flit_injector (SRC_ID=0, DEPTH=4, SYNC_STAGES=2).
module tb_noc_flit_injector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [6:0]  in_payload;
  logic        out_req;
  logic        out_ack;
  logic [10:0] out_flit;
  logic        drop_pulse;
  logic [15:0] pkt_cnt;

  logic ackMode;
  logic routerAck;
  logic manualAck;
  int   checkCount;
  int   errorCount;
  int   expPkt;

  noc_flit_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dest    (in_dest),
    .in_payload (in_payload),
    .out_req    (out_req),
    .out_ack    (out_ack),
    .out_flit   (out_flit),
    .drop_pulse (drop_pulse),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal router: ack follows req half a cycle later.
  always @(negedge clk) routerAck <= out_req;
  assign out_ack = ackMode ? routerAck : manualAck;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] dest, input logic [6:0] payload);
    in_valid   = 1'b1;
    in_dest    = dest;
    in_payload = payload;
    tick(1);
    in_valid   = 1'b0;
  endtask

  task automatic waitReq(input logic level, input string tag);
    for (int i = 0; i < 40 && out_req !== level; i++) begin
      tick(1);
    end
    checkOutput(tag, {31'd0, out_req}, {31'd0, level});
  endtask

  function automatic logic [15:0] pktModel(input int n);
`ifdef NOC_INJ_PKT_CNT_EN
    return n[15:0];
`else
    return (n == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  logic [10:0] fillExp [5];

  initial begin
    checkCount = 0;
    errorCount = 0;
    expPkt     = 0;
    ackMode    = 1'b0;
    manualAck  = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_dest    = 2'd0;
    in_payload = 7'd0;
    tick(2);
    checkOutput("rst_req",  {31'd0, out_req}, 32'd0);
    checkOutput("rst_flit", {21'd0, out_flit}, 32'd0);
    checkOutput("rst_drop", {31'd0, drop_pulse}, 32'd0);
    checkOutput("rst_pkt",  {16'd0, pkt_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single flit with minimum latency
    applyStimulus(2'd2, 7'h55);
    checkOutput("single_req_n", {31'd0, out_req}, 32'd0);
    tick(1);
    checkOutput("single_req_n1", {31'd0, out_req}, 32'd1);
    checkOutput("single_flit", {21'd0, out_flit}, 32'h455);
    ackMode = 1'b1;
    waitReq(1'b0, "single_req_fall");
    tick(6);
    expPkt++;
    checkOutput("single_pkt", {16'd0, pkt_cnt}, {16'd0, pktModel(expPkt)});

    // Fill with ack stalled low
    ackMode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fillExp[i] = {2'(i % 3 + 1), 2'b00, 7'(8'h10 + i)};
      applyStimulus(2'(i % 3 + 1), 7'(8'h10 + i));
    end
    checkOutput("fill_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fill_head", {21'd0, out_flit}, {21'd0, fillExp[0]});
    applyStimulus(2'd3, 7'h7F);
    ackMode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitReq(1'b1, "fill_req_rise");
      checkOutput($sformatf("fill_flit%0d", k), {21'd0, out_flit}, {21'd0, fillExp[k]});
      waitReq(1'b0, "fill_req_fall");
    end
    tick(12);
    expPkt += 5;
    checkOutput("fill_no_extra", {31'd0, out_req}, 32'd0);
    checkOutput("fill_ready_back", {31'd0, in_ready}, 32'd1);
    checkOutput("fill_pkt", {16'd0, pkt_cnt}, {16'd0, pktModel(expPkt)});

    // Self-addressed word is dropped
    applyStimulus(2'd0, 7'h33);
    checkOutput("self_drop_hi", {31'd0, drop_pulse}, 32'd1);
    tick(1);
    checkOutput("self_drop_lo", {31'd0, drop_pulse}, 32'd0);
    tick(4);
    checkOutput("self_no_req", {31'd0, out_req}, 32'd0);
    checkOutput("self_ready", {31'd0, in_ready}, 32'd1);

    // Slow ack: req/flit held, req falls SYNC_STAGES+1 edges after ack rises
    ackMode = 1'b0;
    manualAck = 1'b0;
    applyStimulus(2'd3, 7'h2A);
    tick(1);
    checkOutput("slow_req_rise", {31'd0, out_req}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      checkOutput("slow_req_hold", {31'd0, out_req}, 32'd1);
      checkOutput("slow_flit_hold", {21'd0, out_flit}, 32'h62A);
    end
    manualAck = 1'b1;
    tick(2);
    checkOutput("slow_req_edge2", {31'd0, out_req}, 32'd1);
    tick(1);
    checkOutput("slow_req_edge3", {31'd0, out_req}, 32'd0);
    checkOutput("slow_flit_after", {21'd0, out_flit}, 32'h62A);
    manualAck = 1'b0;
    tick(6);
    expPkt++;
    checkOutput("slow_pkt", {16'd0, pkt_cnt}, {16'd0, pktModel(expPkt)});

    // Reset during REQ_HI with a word still queued
    applyStimulus(2'd1, 7'h01);
    applyStimulus(2'd2, 7'h02);
    checkOutput("mid_req_hi", {31'd0, out_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_req_async", {31'd0, out_req}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("mid_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_pkt", {16'd0, pkt_cnt}, 32'd0);
    checkOutput("mid_flit", {21'd0, out_flit}, 32'd0);
    tick(5);
    checkOutput("mid_fifo_empty", {31'd0, out_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
